word_serializer: RTL and testbench

//   Splits one NUM_WORDS*WIDTH-bit word into NUM_WORDS sub-words of WIDTH bits, emitted one per clk.

---
 rtl/serdes_pkg.sv | 14 +
 rtl/word_serializer.sv | 75 +++++++
 tb/tb_word_serializer.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/serdes_pkg.sv
// Shared serializer/deserializer types and the sub-word ordering helper.
// Both ends of the link use the same ordering so they agree on byte order.
package serdes_pkg;

   typedef enum logic {IDLE = 1'b0, SEND = 1'b1} ser_state_t;

   // Maps a transfer position to the sub-word slot within the full word.
   function automatic int unsigned sub_word_idx(input int unsigned cnt,
                                                input int unsigned num_words,
                                                input bit          little_endian);
      return little_endian ? cnt : (num_words - 1 - cnt);
   endfunction

endpackage

// File: rtl/word_serializer.sv
// Splits a wide word into NUM_WORDS sub-words, one per clock, with FIFO-full backpressure.
// The next word may be accepted on the last sub-word cycle, so words stream with no idle cycle.
//
// state | meaning
// IDLE  | no word held; ready for a new word
// SEND  | emitting sub-word cnt of the held word
module word_serializer
   import serdes_pkg::*;
#(
   parameter int unsigned WIDTH         = 8,
   parameter int unsigned NUM_WORDS     = 4,
   parameter bit          LITTLE_ENDIAN = 1'b1
) (
   input  logic                       clk,
   input  logic                       i_reset_n,
   input  logic [WIDTH*NUM_WORDS-1:0] i_data,
   input  logic                       i_dv,
   output logic                       o_ready,
   output logic [WIDTH-1:0]           o_data,
   output logic                       o_dv,
   input  logic                       i_full,
   output logic                       o_busy
);

   localparam int unsigned      CNT_W    = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NUM_WORDS - 1);

   ser_state_t                 state_q, state_d;
   logic [CNT_W-1:0]           cnt_q, cnt_d;
   logic [WIDTH*NUM_WORDS-1:0] shift_q, shift_d;
   logic                       last;
   logic                       load;
   int unsigned                sel_idx;

   always_comb sel_idx = sub_word_idx(32'(cnt_q), NUM_WORDS, LITTLE_ENDIAN);

   assign o_data  = shift_q[sel_idx*WIDTH +: WIDTH];
   assign o_busy  = (state_q == SEND);
   // o_dv is combinational from i_full so the FIFO is never written while full.
   assign o_dv    = o_busy & ~i_full;
   assign last    = (cnt_q == CNT_LAST);
   assign o_ready = ~o_busy | (last & ~i_full);
   assign load    = i_dv & o_ready;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      shift_d = shift_q;
      if (load) begin
         state_d = SEND;
         cnt_d   = '0;
         shift_d = i_data;
      end else if (o_dv) begin
         if (last) begin
            state_d = IDLE;
            cnt_d   = '0;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         shift_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         shift_q <= shift_d;
      end
   end

endmodule

// File: tb/tb_word_serializer.sv
// Directed bench for word_serializer: little- and big-endian instances share stimulus,
// and each emitted byte is checked against a per-instance expected-byte queue.
module tb_word_serializer;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] i_data;
   logic        i_dv;
   logic        i_full;

   logic [7:0] data_o  [2];
   logic       dv_o    [2];
   logic       busy_o  [2];
   logic       ready_o [2];

   logic [7:0] q_le [$];
   logic [7:0] q_be [$];

   int vectors     = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   word_serializer #(.WIDTH(8), .NUM_WORDS(4), .LITTLE_ENDIAN(1'b1)) dut_le (
      .clk(clk), .i_reset_n(rst_n), .i_data(i_data), .i_dv(i_dv),
      .o_ready(ready_o[0]), .o_data(data_o[0]), .o_dv(dv_o[0]),
      .i_full(i_full), .o_busy(busy_o[0])
   );

   word_serializer #(.WIDTH(8), .NUM_WORDS(4), .LITTLE_ENDIAN(1'b0)) dut_be (
      .clk(clk), .i_reset_n(rst_n), .i_data(i_data), .i_dv(i_dv),
      .o_ready(ready_o[1]), .o_data(data_o[1]), .o_dv(dv_o[1]),
      .i_full(i_full), .o_busy(busy_o[1])
   );

   task automatic chk(input string tag, input int k, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s_%s observed=%0h expected=%0h", (k == 0) ? "le" : "be", tag, obs, exp);
      end
   endtask

   task automatic push_word(input logic [31:0] w);
      for (int i = 0; i < 4; i++) begin
         q_le.push_back(w[8*i +: 8]);
         q_be.push_back(w[8*(3-i) +: 8]);
      end
   endtask

   task automatic mon(input logic exp_ready);
      int         sz;
      logic [7:0] front;
      for (int k = 0; k < 2; k++) begin
         chk("ready", k, 32'(ready_o[k]), 32'(exp_ready));
         sz = (k == 0) ? q_le.size() : q_be.size();
         if (busy_o[k]) begin
            chk("dv", k, 32'(dv_o[k]), 32'(!i_full));
            chk("q_nonempty", k, 32'(sz > 0), 32'd1);
            if (sz > 0) begin
               front = (k == 0) ? q_le[0] : q_be[0];
               chk("data", k, 32'(data_o[k]), 32'(front));
               if (dv_o[k]) begin
                  if (k == 0) void'(q_le.pop_front());
                  else        void'(q_be.pop_front());
               end
            end
         end else begin
            chk("idle_dv", k, 32'(dv_o[k]), 32'd0);
         end
      end
   endtask

   task automatic cyc(input logic dv, input logic [31:0] d, input logic full, input logic exp_ready);
      @(posedge clk);
      #1;
      i_dv   = dv;
      i_data = d;
      i_full = full;
      @(negedge clk);
      mon(exp_ready);
   endtask

   task automatic chk_reset();
      for (int k = 0; k < 2; k++) begin
         chk("rst_dv",    k, 32'(dv_o[k]),    32'd0);
         chk("rst_busy",  k, 32'(busy_o[k]),  32'd0);
         chk("rst_ready", k, 32'(ready_o[k]), 32'd1);
         chk("rst_data",  k, 32'(data_o[k]),  32'd0);
      end
   endtask

   initial begin
      rst_n  = 1'b0;
      i_dv   = 1'b0;
      i_data = '0;
      i_full = 1'b0;
      #12;
      chk_reset();
      @(negedge clk);
      rst_n = 1'b1;

      // Single word, no backpressure
      cyc(1'b1, 32'hDDCCBBAA, 1'b0, 1'b1); push_word(32'hDDCCBBAA);
      cyc(1'b0, 32'h0, 1'b0, 1'b0);
      cyc(1'b0, 32'h0, 1'b0, 1'b0);
      cyc(1'b0, 32'h0, 1'b0, 1'b0);
      cyc(1'b0, 32'h0, 1'b0, 1'b1);
      cyc(1'b0, 32'h0, 1'b0, 1'b1);

      // Two words back to back with i_dv held high
      cyc(1'b1, 32'h04030201, 1'b0, 1'b1); push_word(32'h04030201);
      cyc(1'b1, 32'h08070605, 1'b0, 1'b0);
      cyc(1'b1, 32'h08070605, 1'b0, 1'b0);
      cyc(1'b1, 32'h08070605, 1'b0, 1'b0);
      cyc(1'b1, 32'h08070605, 1'b0, 1'b1); push_word(32'h08070605);
      cyc(1'b0, 32'h0, 1'b0, 1'b0);
      cyc(1'b0, 32'h0, 1'b0, 1'b0);
      cyc(1'b0, 32'h0, 1'b0, 1'b0);
      cyc(1'b0, 32'h0, 1'b0, 1'b1);
      cyc(1'b0, 32'h0, 1'b0, 1'b1);

      // Full stall on the second byte, then on the last byte
      cyc(1'b1, 32'hDDCCBBAA, 1'b0, 1'b1); push_word(32'hDDCCBBAA);
      cyc(1'b0, 32'h0, 1'b0, 1'b0);
      cyc(1'b0, 32'h0, 1'b1, 1'b0);
      cyc(1'b0, 32'h0, 1'b1, 1'b0);
      cyc(1'b0, 32'h0, 1'b1, 1'b0);
      cyc(1'b0, 32'h0, 1'b0, 1'b0);
      cyc(1'b0, 32'h0, 1'b0, 1'b0);
      cyc(1'b1, 32'h55555555, 1'b1, 1'b0);
      cyc(1'b1, 32'h55555555, 1'b1, 1'b0);
      cyc(1'b0, 32'h0, 1'b0, 1'b1);
      cyc(1'b0, 32'h0, 1'b0, 1'b1);

      // Reset in the middle of a word
      cyc(1'b1, 32'hDDCCBBAA, 1'b0, 1'b1); push_word(32'hDDCCBBAA);
      cyc(1'b0, 32'h0, 1'b0, 1'b0);
      cyc(1'b0, 32'h0, 1'b0, 1'b0);
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk_reset();
      q_le.delete();
      q_be.delete();
      @(negedge clk);
      rst_n = 1'b1;
      cyc(1'b1, 32'h00AA00AA, 1'b0, 1'b1); push_word(32'h00AA00AA);
      cyc(1'b0, 32'h0, 1'b0, 1'b0);
      cyc(1'b0, 32'h0, 1'b0, 1'b0);
      cyc(1'b0, 32'h0, 1'b0, 1'b0);
      cyc(1'b0, 32'h0, 1'b0, 1'b1);
      cyc(1'b0, 32'h0, 1'b0, 1'b1);

      // i_dv during non-last SEND cycles is ignored
      cyc(1'b1, 32'h11223344, 1'b0, 1'b1); push_word(32'h11223344);
      cyc(1'b1, 32'hFFFFFFFF, 1'b0, 1'b0);
      cyc(1'b1, 32'hFFFFFFFF, 1'b0, 1'b0);
      cyc(1'b1, 32'hFFFFFFFF, 1'b0, 1'b0);
      cyc(1'b0, 32'h0, 1'b0, 1'b1);
      cyc(1'b0, 32'h0, 1'b0, 1'b1);
      cyc(1'b0, 32'h0, 1'b0, 1'b1);

      chk("q_drained", 0, 32'(q_le.size()), 32'd0);
      chk("q_drained", 1, 32'(q_be.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
